// File: rtl/tank_drive_mapper.sv
// Maps debounced per-player 4-way joystick + fire onto two-level tank track commands,
// with selectable drive modes, PWM half-speed diagonals and a per-track reversal guard.
module tank_drive_mapper #(
   parameter int NUM_PLAYERS     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PWM_BITS        = 3,
   parameter int GUARD_CYCLES    = 2
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     ce,
   input  logic [1:0]               mode,
   input  logic [5*NUM_PLAYERS-1:0] joy_in,
   output logic [NUM_PLAYERS-1:0]   trk_l_fw,
   output logic [NUM_PLAYERS-1:0]   trk_l_bk,
   output logic [NUM_PLAYERS-1:0]   trk_r_fw,
   output logic [NUM_PLAYERS-1:0]   trk_r_bk,
   output logic [NUM_PLAYERS-1:0]   fire_out,
   output logic [NUM_PLAYERS-1:0]   active
);

   localparam int NB = 5 * NUM_PLAYERS;
   localparam int NT = 2 * NUM_PLAYERS;  // track 2p = left, 2p+1 = right

   typedef enum logic [1:0] {
      DIR_STOP = 2'd0,
      DIR_FW   = 2'd1,
      DIR_BK   = 2'd2
   } dir_t;

   typedef struct packed {
      dir_t l;
      dir_t r;
   } pair_t;

   logic [NB-1:0]       db_q;
   logic [7:0]          db_cnt [NB];
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [1:0]          mode_q;
   dir_t                last_dir [NT];
   logic [7:0]          guard_cnt [NT];

   pair_t                  pairs [NUM_PLAYERS];
   dir_t                   req [NT];
   logic [NUM_PLAYERS-1:0] dir_valid;
   dir_t                   drv [NT];
   dir_t                   last_nx [NT];
   logic [7:0]             guard_nx [NT];

   function automatic logic is_neutral(input logic [3:0] udlr);
      // Any opposing pair is neutral; three or four bits always contain one.
      return (udlr[3] && udlr[2]) || (udlr[1] && udlr[0]);
   endfunction

   function automatic pair_t map_dir(input logic [3:0] udlr, input logic [1:0] md,
                                     input logic pwm_off);
      pair_t pr;
      logic  diag;
      pr   = '{DIR_STOP, DIR_STOP};
      diag = (udlr[3] || udlr[2]) && (udlr[1] || udlr[0]);
      if (is_neutral(udlr)) begin
         pr = '{DIR_STOP, DIR_STOP};
      end else if (md == 2'd1 && udlr[3]) begin
         pr = '{DIR_FW, DIR_FW};
      end else if (md == 2'd1 && udlr[2]) begin
         pr = '{DIR_BK, DIR_BK};
      end else begin
         case (udlr)
            4'b1000: pr = '{DIR_FW,   DIR_FW};
            4'b1010: pr = '{DIR_STOP, DIR_FW};
            4'b1001: pr = '{DIR_FW,   DIR_STOP};
            4'b0001: pr = '{DIR_FW,   DIR_BK};
            4'b0101: pr = '{DIR_BK,   DIR_STOP};
            4'b0100: pr = '{DIR_BK,   DIR_BK};
            4'b0110: pr = '{DIR_STOP, DIR_BK};
            4'b0010: pr = '{DIR_BK,   DIR_FW};
            default: pr = '{DIR_STOP, DIR_STOP};
         endcase
      end
      if (md == 2'd2 && diag && pwm_off) pr = '{DIR_STOP, DIR_STOP};
      return pr;
   endfunction

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         db_q <= '0;
         for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
      end else if (ce) begin
         for (int i = 0; i < NB; i++) begin
            if (joy_in[i] == db_q[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
               db_q[i]   <= joy_in[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
         end
      end
   end

   // The half-speed phase restarts whenever the mode input changes, ce or not.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pwm_cnt <= '0;
         mode_q  <= '0;
      end else begin
         mode_q <= mode;
         if (mode != mode_q) pwm_cnt <= '0;
         else if (ce)        pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      dir_valid = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         pairs[p]      = map_dir(db_q[5*p +: 4], mode, pwm_cnt[PWM_BITS-1]);
         req[2*p]      = pairs[p].l;
         req[2*p+1]    = pairs[p].r;
         dir_valid[p]  = (|db_q[5*p +: 4]) && !is_neutral(db_q[5*p +: 4]);
      end
   end

   // Reversal guard: last_dir holds the direction being protected while guard_cnt is non-zero.
   always_comb begin
      for (int t = 0; t < NT; t++) begin
         drv[t]      = req[t];
         last_nx[t]  = last_dir[t];
         guard_nx[t] = guard_cnt[t];
         if (guard_cnt[t] != 8'd0) begin
            if (req[t] == last_dir[t] || req[t] == DIR_STOP) begin
               last_nx[t]  = req[t];
               guard_nx[t] = 8'd0;
            end else begin
               drv[t] = DIR_STOP;
               if (ce) begin
                  if (guard_cnt[t] == 8'd1) begin
                     drv[t]      = req[t];
                     last_nx[t]  = req[t];
                     guard_nx[t] = 8'd0;
                  end else begin
                     guard_nx[t] = guard_cnt[t] - 8'd1;
                  end
               end
            end
         end else if (GUARD_CYCLES != 0 && req[t] != DIR_STOP &&
                      last_dir[t] != DIR_STOP && req[t] != last_dir[t]) begin
            drv[t]      = DIR_STOP;
            guard_nx[t] = 8'(GUARD_CYCLES);
         end else begin
            last_nx[t] = req[t];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         trk_l_fw <= '0;
         trk_l_bk <= '0;
         trk_r_fw <= '0;
         trk_r_bk <= '0;
         fire_out <= '0;
         active   <= '0;
         for (int t = 0; t < NT; t++) begin
            last_dir[t]  <= DIR_STOP;
            guard_cnt[t] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            trk_l_fw[p] <= (drv[2*p]   == DIR_FW);
            trk_l_bk[p] <= (drv[2*p]   == DIR_BK);
            trk_r_fw[p] <= (drv[2*p+1] == DIR_FW);
            trk_r_bk[p] <= (drv[2*p+1] == DIR_BK);
            fire_out[p] <= db_q[5*p+4];
            active[p]   <= dir_valid[p];
         end
         for (int t = 0; t < NT; t++) begin
            last_dir[t]  <= last_nx[t];
            guard_cnt[t] <= guard_nx[t];
         end
      end
   end

endmodule
